// File: rtl/spu_mastq_if.sv
// spu_mastq_if
//   Store request bus between the MA store-issue queue and the LSU.
//
//   Handshake: spu_lsu_st_req is a valid that, once raised, holds together
//   with spu_lsu_st_addr/spu_lsu_st_data unchanged until the LSU samples
//   lsu_spu_st_gnt high on a rising edge (gnt acts as ready; a gnt seen
//   while req is low has no effect). lsu_spu_st_ack is an independent
//   one-cycle completion strobe, one per previously granted store.
//
//   Signals:
//     spu_lsu_st_req   store request valid (queue -> LSU)
//     spu_lsu_st_addr  physical address PA[39:3] (queue -> LSU)
//     spu_lsu_st_data  store data (queue -> LSU)
//     lsu_spu_st_gnt   request accepted this cycle (LSU -> queue)
//     lsu_spu_st_ack   one store completed (LSU -> queue)
interface spu_mastq_if #(
  parameter int DW = 64,
  parameter int AW = 37
);
  logic          spu_lsu_st_req;
  logic [AW-1:0] spu_lsu_st_addr;
  logic [DW-1:0] spu_lsu_st_data;
  logic          lsu_spu_st_gnt;
  logic          lsu_spu_st_ack;

  modport master (
    output spu_lsu_st_req,
    output spu_lsu_st_addr,
    output spu_lsu_st_data,
    input  lsu_spu_st_gnt,
    input  lsu_spu_st_ack
  );

  modport slave (
    input  spu_lsu_st_req,
    input  spu_lsu_st_addr,
    input  spu_lsu_st_data,
    output lsu_spu_st_gnt,
    output lsu_spu_st_ack
  );
endinterface

// File: rtl/spu_mastq.sv
// spu_mastq
//   Store-issue queue between the MA store sequencer and the LSU. Words read
//   from MA memory are buffered in a 2-entry FIFO; each sequencer store
//   request launches the FIFO head to the LSU at an auto-incrementing
//   address. Granted-but-unacked stores are counted so the sequencer can
//   wait for all MA stores to be acknowledged.
//
//   Optional feature macro: SPU_MASTQ_PARITY_EN (even parity per entry,
//   rechecked at launch; a bad entry is discarded and spu_mastq_perr pulses).
//
//   Ports:
//     rclk, arst_l                 clock, async active-low reset
//     se                           scan enable (no functional use here)
//     spu_mactl_iss_pulse_dly      new op: load address, clear overflow
//     spu_mactl_mpa                start address (8-byte units)
//     spu_mast_stbuf_wen           push spu_madp_memrd_data into the FIFO
//     spu_madp_memrd_data          word read from MA memory
//     spu_mast_streq               request one store from the FIFO head
//     spu_mactl_stxa_force_abort   flush FIFO, pending requests, held req
//     lsu                          LSU store request bus (master side)
//     spu_mast_streq_ack           one-cycle pulse per accepted LSU ack
//     spu_wen_allma_stacks_ok      nothing buffered, pending or outstanding
//     spu_mastq_ovfl               sticky FIFO overflow
//     spu_mastq_perr               parity error pulse
module spu_mastq #(
  parameter int DW = 64,
  parameter int AW = 37
) (
  input  logic               rclk,
  input  logic               arst_l,
  input  logic               se,
  input  logic               spu_mactl_iss_pulse_dly,
  input  logic [AW-1:0]      spu_mactl_mpa,
  input  logic               spu_mast_stbuf_wen,
  input  logic [DW-1:0]      spu_madp_memrd_data,
  input  logic               spu_mast_streq,
  input  logic               spu_mactl_stxa_force_abort,
  spu_mastq_if.master        lsu,
  output logic               spu_mast_streq_ack,
  output logic               spu_wen_allma_stacks_ok,
  output logic               spu_mastq_ovfl,
  output logic               spu_mastq_perr
);

  logic [1:0][DW-1:0] mem_q, mem_d;
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         pend_q, pend_d;
  logic [2:0]         out_q, out_d;
  logic [AW-1:0]      areg_q, areg_d;
  logic               req_q, req_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic               sack_q, sack_d;
  logic               ovfl_q, ovfl_d;
  logic               perr_q, perr_d;

  logic fifo_empty, fifo_full, gnt_acc, ack_acc;
  logic launch_try, launch_ok, par_bad, wr_acc, ovfl_set;

  logic unused_se;
  assign unused_se = se;

  assign fifo_empty = (cnt_q == 2'd0);
  assign fifo_full  = (cnt_q == 2'd2);
  assign gnt_acc    = req_q & lsu.lsu_spu_st_gnt;
  assign ack_acc    = lsu.lsu_spu_st_ack & (out_q != 3'd0);
  // A launch attempt pops the head whether or not its parity is good.
  assign launch_try = (pend_q != 2'd0) & ~fifo_empty & ~req_q &
                      ~spu_mactl_stxa_force_abort;
  assign launch_ok  = launch_try & ~par_bad;
  // A full FIFO can still accept a write in the cycle its head pops.
  assign wr_acc     = spu_mast_stbuf_wen & ~spu_mactl_stxa_force_abort &
                      (~fifo_full | launch_try);
  assign ovfl_set   = spu_mast_stbuf_wen & ~spu_mactl_stxa_force_abort &
                      fifo_full & ~launch_try;

`ifdef SPU_MASTQ_PARITY_EN
  logic [1:0] par_q, par_d;
  assign par_bad = (^mem_q[rptr_q]) != par_q[rptr_q];
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    out_d  = out_q;
    areg_d = areg_q;
    req_d  = req_q;
    addr_d = addr_q;
    data_d = data_q;
    sack_d = ack_acc;
    ovfl_d = ovfl_q;
    perr_d = launch_try & par_bad;
`ifdef SPU_MASTQ_PARITY_EN
    par_d  = par_q;
`endif

    if (wr_acc) begin
      mem_d[wptr_q] = spu_madp_memrd_data;
`ifdef SPU_MASTQ_PARITY_EN
      par_d[wptr_q] = ^spu_madp_memrd_data;
`endif
      wptr_d = ~wptr_q;
    end
    if (launch_try) rptr_d = ~rptr_q;

    case ({wr_acc, launch_try})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    case ({spu_mast_streq, launch_try})
      2'b10:   pend_d = (pend_q == 2'd3) ? pend_q : pend_q + 2'd1;
      2'b01:   pend_d = pend_q - 2'd1;
      default: pend_d = pend_q;
    endcase

    if (spu_mactl_stxa_force_abort) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
      pend_d = 2'd0;
    end

    // Grant wins over abort so a store the LSU has accepted is always counted.
    if (gnt_acc) begin
      req_d = 1'b0;
    end else if (spu_mactl_stxa_force_abort) begin
      req_d = 1'b0;
    end else if (launch_ok) begin
      req_d  = 1'b1;
      addr_d = areg_q;
      data_d = mem_q[rptr_q];
    end

    if (spu_mactl_iss_pulse_dly) areg_d = spu_mactl_mpa;
    else if (gnt_acc)            areg_d = areg_q + {{(AW-1){1'b0}}, 1'b1};

    case ({gnt_acc, ack_acc})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase

    if (spu_mactl_iss_pulse_dly) ovfl_d = 1'b0;
    else if (ovfl_set)           ovfl_d = 1'b1;
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      mem_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
      pend_q <= 2'd0;
      out_q  <= 3'd0;
      areg_q <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      sack_q <= 1'b0;
      ovfl_q <= 1'b0;
      perr_q <= 1'b0;
`ifdef SPU_MASTQ_PARITY_EN
      par_q  <= 2'b00;
`endif
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      areg_q <= areg_d;
      req_q  <= req_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sack_q <= sack_d;
      ovfl_q <= ovfl_d;
      perr_q <= perr_d;
`ifdef SPU_MASTQ_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  assign lsu.spu_lsu_st_req  = req_q;
  assign lsu.spu_lsu_st_addr = addr_q;
  assign lsu.spu_lsu_st_data = data_q;
  assign spu_mast_streq_ack  = sack_q;
  assign spu_mastq_ovfl      = ovfl_q;
  assign spu_mastq_perr      = perr_q;
  assign spu_wen_allma_stacks_ok = (out_q == 3'd0) & fifo_empty &
                                   (pend_q == 2'd0) & ~req_q;

endmodule

// File: tb/tb_spu_mastq.sv
// tb_spu_mastq
//   Directed bench for spu_mastq: a per-cycle vector table (inputs plus the
//   registered outputs expected right after that cycle's rising edge) and
//   hand-written sequences for asynchronous reset and, when
//   SPU_MASTQ_PARITY_EN is defined, parity-error handling.
module tb_spu_mastq;

  localparam int DW = 64;
  localparam int AW = 37;

  localparam logic [DW-1:0] D1 = 64'hA5A5_0000_0000_0001;
  localparam logic [DW-1:0] D2 = 64'h1111_2222_3333_4444;
  localparam logic [DW-1:0] D3 = 64'h5555_6666_7777_8888;
  localparam logic [DW-1:0] DA = 64'h0000_0000_0000_00AA;
  localparam logic [DW-1:0] DB = 64'h0000_0000_0000_00BB;
  localparam logic [DW-1:0] DC = 64'h0000_0000_0000_00CC;
  localparam logic [DW-1:0] DE = 64'hDEAD_BEEF_0000_00EE;
  localparam logic [DW-1:0] DF = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [DW-1:0] DG = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [DW-1:0] DH = 64'h1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] DI = 64'hFEDC_BA98_7654_3210;
  localparam logic [DW-1:0] W1 = 64'h0000_0001_0000_0001;
  localparam logic [DW-1:0] W2 = 64'h0000_0002_0000_0002;
  localparam logic [AW-1:0] AMAX = {AW{1'b1}};

  // clock / reset
  logic rclk = 1'b0;
  logic arst_l = 1'b0;
  always #5 rclk = ~rclk;

  logic          se = 1'b0;
  logic          iss = 1'b0;
  logic [AW-1:0] mpa = '0;
  logic          wen = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          streq = 1'b0;
  logic          abort = 1'b0;
  logic          sack, ok, ovfl, perr;

  spu_mastq_if #(.DW(DW), .AW(AW)) lsu_if ();

  spu_mastq #(.DW(DW), .AW(AW)) dut (
    .rclk                       (rclk),
    .arst_l                     (arst_l),
    .se                         (se),
    .spu_mactl_iss_pulse_dly    (iss),
    .spu_mactl_mpa              (mpa),
    .spu_mast_stbuf_wen         (wen),
    .spu_madp_memrd_data        (wdata),
    .spu_mast_streq             (streq),
    .spu_mactl_stxa_force_abort (abort),
    .lsu                        (lsu_if),
    .spu_mast_streq_ack         (sack),
    .spu_wen_allma_stacks_ok    (ok),
    .spu_mastq_ovfl             (ovfl),
    .spu_mastq_perr             (perr)
  );

  typedef struct {
    logic          iss;
    logic [AW-1:0] mpa;
    logic          wen;
    logic [DW-1:0] wd;
    logic          streq, abort, gnt, ack;
    logic          e_req;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_sack, e_ok, e_ovfl;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic i_iss, logic [AW-1:0] i_mpa, logic i_wen,
                              logic [DW-1:0] i_wd, logic i_streq, logic i_abort,
                              logic i_gnt, logic i_ack, logic x_req,
                              logic [AW-1:0] x_addr, logic [DW-1:0] x_data,
                              logic x_sack, logic x_ok, logic x_ovfl);
    vec_t v;
    v.iss = i_iss; v.mpa = i_mpa; v.wen = i_wen; v.wd = i_wd;
    v.streq = i_streq; v.abort = i_abort; v.gnt = i_gnt; v.ack = i_ack;
    v.e_req = x_req; v.e_addr = x_addr; v.e_data = x_data;
    v.e_sack = x_sack; v.e_ok = x_ok; v.e_ovfl = x_ovfl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: present inputs on the falling edge, sample 1 ns after the rise
  task automatic drive(input logic i_iss, input logic [AW-1:0] i_mpa,
                       input logic i_wen, input logic [DW-1:0] i_wd,
                       input logic i_streq, input logic i_abort,
                       input logic i_gnt, input logic i_ack);
    @(negedge rclk);
    iss = i_iss; mpa = i_mpa; wen = i_wen; wdata = i_wd;
    streq = i_streq; abort = i_abort;
    lsu_if.lsu_spu_st_gnt = i_gnt; lsu_if.lsu_spu_st_ack = i_ack;
    @(posedge rclk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},  {63'd0, lsu_if.spu_lsu_st_req}, 64'd0);
    chk({tag, "_addr"}, {27'd0, lsu_if.spu_lsu_st_addr}, 64'd0);
    chk({tag, "_data"}, lsu_if.spu_lsu_st_data, 64'd0);
    chk({tag, "_sack"}, {63'd0, sack}, 64'd0);
    chk({tag, "_ok"},   {63'd0, ok},   64'd1);
    chk({tag, "_ovfl"}, {63'd0, ovfl}, 64'd0);
    chk({tag, "_perr"}, {63'd0, perr}, 64'd0);
  endtask

  initial begin
    lsu_if.lsu_spu_st_gnt = 1'b0;
    lsu_if.lsu_spu_st_ack = 1'b0;

    //         iss mpa     wen wd streq abt gnt ack | req addr    data sack ok ovfl
    // basic store
    vecs.push_back(mk(1, 'h100, 0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 1, 0));
    vecs.push_back(mk(0, 0,     1, D1, 0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h100,  D1, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h100,  D1, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 1, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 1,  0, 0,      0,  1, 1, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 1, 0));
    // back-to-back with grant held off
    vecs.push_back(mk(1, 'h100, 1, D2, 0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     1, D3, 1, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0, 0,  1, 'h100,  D2, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h100,  D2, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h100,  D2, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h100,  D2, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 1, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h101,  D3, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 1, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 1,  0, 0,      0,  1, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 1,  0, 0,      0,  1, 1, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 1, 0));
    // overflow, dropped third word, then gnt+ack in the same cycle
    vecs.push_back(mk(0, 0,     1, DA, 0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     1, DB, 0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     1, DC, 0, 0, 0, 0,  0, 0,      0,  0, 0, 1));
    vecs.push_back(mk(1, 'h200, 0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0, 0,  1, 'h200,  DA, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 1, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h201,  DB, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 1, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 1,  0, 0,      0,  1, 0, 0));
    vecs.push_back(mk(0, 0,     1, DE, 0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h202,  DE, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 1, 1,  0, 0,      0,  1, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 1,  0, 0,      0,  1, 1, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 1, 0));
    // abort with a full FIFO and an ungranted request, one store in flight
    vecs.push_back(mk(0, 0,     1, DF, 1, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     1, DG, 0, 0, 0, 0,  1, 'h203,  DF, 0, 0, 0));
    vecs.push_back(mk(0, 0,     1, DH, 0, 0, 1, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     1, DI, 1, 0, 0, 0,  1, 'h204,  DG, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 'h204,  DG, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 1, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 1,  0, 0,      0,  1, 1, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 1, 0));
    // address wrap at the top of the address space
    vecs.push_back(mk(1, AMAX,  1, W1, 0, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     1, W2, 1, 0, 0, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  1, 0, 0, 0,  1, AMAX,   W1, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 1, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  1, 0,      W2, 0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 1, 0,  0, 0,      0,  0, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 1,  0, 0,      0,  1, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 1,  0, 0,      0,  1, 1, 0));
    vecs.push_back(mk(0, 0,     0, 0,  0, 0, 0, 0,  0, 0,      0,  0, 1, 0));

    // reset state, held in reset then just after release
    repeat (2) @(negedge rclk);
    chk_reset_vals("rst_hold");
    @(negedge rclk);
    arst_l = 1'b1;
    @(posedge rclk);
    #1;
    chk_reset_vals("rst_rel");

    // table
    foreach (vecs[i]) begin
      drive(vecs[i].iss, vecs[i].mpa, vecs[i].wen, vecs[i].wd, vecs[i].streq,
            vecs[i].abort, vecs[i].gnt, vecs[i].ack);
      chk($sformatf("v%0d_req", i), {63'd0, lsu_if.spu_lsu_st_req},
          {63'd0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_addr", i), {27'd0, lsu_if.spu_lsu_st_addr},
            {27'd0, vecs[i].e_addr});
        chk($sformatf("v%0d_data", i), lsu_if.spu_lsu_st_data, vecs[i].e_data);
      end
      chk($sformatf("v%0d_sack", i), {63'd0, sack}, {63'd0, vecs[i].e_sack});
      chk($sformatf("v%0d_ok", i),   {63'd0, ok},   {63'd0, vecs[i].e_ok});
      chk($sformatf("v%0d_ovfl", i), {63'd0, ovfl}, {63'd0, vecs[i].e_ovfl});
      chk($sformatf("v%0d_perr", i), {63'd0, perr}, 64'd0);
    end
    idle();

    // asynchronous reset in the middle of a held request (address reg is 1)
    drive(1'b0, '0, 1'b1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, D2, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, D3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_pre_req",  {63'd0, lsu_if.spu_lsu_st_req}, 64'd1);
    chk("arst_pre_addr", {27'd0, lsu_if.spu_lsu_st_addr}, 64'd1);
    chk("arst_pre_data", lsu_if.spu_lsu_st_data, D1);
    drive(1'b0, '0, 1'b1, DA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_pre_ovfl", {63'd0, ovfl}, 64'd1);
    #2;
    arst_l = 1'b0;
    #1;
    chk_reset_vals("arst_mid");
    wen = 1'b0;
    @(negedge rclk);
    arst_l = 1'b1;
    idle();
    chk_reset_vals("arst_after");

`ifdef SPU_MASTQ_PARITY_EN
    begin
      logic [1:0][DW-1:0] tmp;
      drive(1'b0, '0, 1'b1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, D2, 1'b0, 1'b0, 1'b0, 1'b0);
      tmp = dut.mem_q;
      tmp[0][3] = ~tmp[0][3];
      force dut.mem_q = tmp;
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      release dut.mem_q;
      idle();
      chk("par_req",   {63'd0, lsu_if.spu_lsu_st_req}, 64'd0);
      chk("par_perr1", {63'd0, perr}, 64'd1);
      idle();
      chk("par_perr0", {63'd0, perr}, 64'd0);
      chk("par_req2",  {63'd0, lsu_if.spu_lsu_st_req}, 64'd0);
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      chk("par_nxt_req",  {63'd0, lsu_if.spu_lsu_st_req}, 64'd1);
      chk("par_nxt_data", lsu_if.spu_lsu_st_data, D2);
      chk("par_nxt_addr", {27'd0, lsu_if.spu_lsu_st_addr}, 64'd0);
      chk("par_nxt_perr", {63'd0, perr}, 64'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
